// File: rtl/flag_forward_unit.sv
// Flag pipe from EX to WB commit, with zero-latency forwarding into decode-stage
// branch evaluation and a saturating taken-branch counter.
module flag_forward_unit #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic             ex_set_flags,
    input  logic [1:0]       ex_flags,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    output logic             br_taken,
    output logic [1:0]       flags_q,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [2:0] CC_AL = 3'd0, CC_EQ = 3'd1, CC_NE = 3'd2, CC_LT = 3'd3,
                           CC_GE = 3'd4, CC_LE = 3'd5, CC_GT = 3'd6;

    // Flags are {N,Z}: bit 1 = N, bit 0 = Z.
    function automatic logic cond_eval(input logic [2:0] cc, input logic [1:0] f);
        logic z;
        logic n;
        z = f[0];
        n = f[1];
        case (cc)
            CC_AL:   cond_eval = 1'b1;
            CC_EQ:   cond_eval = z;
            CC_NE:   cond_eval = !z;
            CC_LT:   cond_eval = n;
            CC_GE:   cond_eval = !n;
            CC_LE:   cond_eval = z | n;
            CC_GT:   cond_eval = !z & !n;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    logic [DEPTH-1:0] stage_v;
    logic [1:0]       stage_f [DEPTH];
    logic             ex_wr;
    logic [1:0]       eff_flags;
    logic             cnt_en;

    assign ex_wr = ex_valid & ex_set_flags;

    // Stage 0..DEPTH-1: in-flight writers, commit from the oldest entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_v <= '0;
            flags_q <= 2'b00;
            for (int i = 0; i < DEPTH; i++) stage_f[i] <= 2'b00;
        end else if (flush) begin
            // The oldest writer predates the flushing branch, so it still retires.
            if (stage_v[DEPTH-1]) flags_q <= stage_f[DEPTH-1];
            stage_v <= '0;
        end else if (!stall) begin
            if (stage_v[DEPTH-1]) flags_q <= stage_f[DEPTH-1];
            stage_v[0] <= ex_wr;
            stage_f[0] <= ex_flags;
            for (int i = 1; i < DEPTH; i++) begin
                stage_v[i] <= stage_v[i-1];
                stage_f[i] <= stage_f[i-1];
            end
        end
    end

    // Youngest writer wins: EX, then lowest-index valid stage, then committed flags.
    always_comb begin
        eff_flags = flags_q;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (stage_v[i]) eff_flags = stage_f[i];
        end
        if (ex_wr && !flush) eff_flags = ex_flags;
    end

    assign br_taken = br_valid & cond_eval(br_cond, eff_flags);
    assign cnt_en   = br_taken & !stall & !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken_cnt <= '0;
        end else if (cnt_en) begin
            taken_cnt <= sat_inc(taken_cnt);
        end
    end

endmodule

// File: tb/tb_flag_forward_unit.sv
// Directed bench for flag_forward_unit: queue-based reference model checked every
// cycle, plus literal expectations for reset, latency, forwarding, stall, flush, saturation.
module tb_flag_forward_unit;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             stall, flush, ex_valid, ex_set_flags, br_valid;
    logic [1:0]       ex_flags;
    logic [2:0]       br_cond;
    logic             br_taken;
    logic [1:0]       flags_q;
    logic [CNT_W-1:0] taken_cnt;

    flag_forward_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_set_flags(ex_set_flags), .ex_flags(ex_flags),
        .br_valid(br_valid), .br_cond(br_cond), .br_taken(br_taken),
        .flags_q(flags_q), .taken_cnt(taken_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    bit done  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a queue of in-flight writers, index 0 = youngest.
    logic [2:0] q[$];
    logic [1:0] m_flags;
    int         m_cnt;

    function automatic logic cond_ref(input logic [2:0] c, input logic [1:0] f);
        logic [7:0] tbl;
        // Columns in cc order: AL EQ NE LT GE LE GT NV, evaluated for this N,Z.
        tbl = {1'b0, (f == 2'b00), 1'b1 & (f != 2'b00), f[1], ~f[1], f[1], ~f[0], f[0], 1'b1} >> 1;
        tbl = {1'b0, (f == 2'b00), (f != 2'b00), ~f[1], f[1], ~f[0], f[0], 1'b1};
        return tbl[c];
    endfunction

    function automatic logic model_taken();
        logic [1:0] f;
        bit         found;
        f = m_flags;
        found = 1'b0;
        if (ex_valid && ex_set_flags && !flush) begin
            f = ex_flags;
        end else begin
            foreach (q[i]) begin
                if (!found && q[i][2]) begin
                    f = q[i][1:0];
                    found = 1'b1;
                end
            end
        end
        return br_valid && cond_ref(br_cond, f);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q = {};
            for (int i = 0; i < DEPTH; i++) q.push_back(3'b000);
            m_flags = 2'b00;
            m_cnt   = 0;
        end else if (flush) begin
            if (q[DEPTH-1][2]) m_flags = q[DEPTH-1][1:0];
            foreach (q[i]) q[i] = {1'b0, q[i][1:0]};
        end else if (!stall) begin
            if (model_taken() && m_cnt < CNT_MAX) m_cnt++;
            if (q[DEPTH-1][2]) m_flags = q[DEPTH-1][1:0];
            void'(q.pop_back());
            q.push_front({ex_valid & ex_set_flags, ex_flags});
        end
    end

    always @(negedge clk) begin
        #3;
        if (!done) begin
            chk("cmp_flags_q", flags_q, m_flags);
            chk("cmp_taken_cnt", taken_cnt, m_cnt);
            chk("cmp_br_taken", br_taken, model_taken());
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic ex_write(input logic [1:0] f);
        ex_valid = 1'b1; ex_set_flags = 1'b1; ex_flags = f;
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0; ex_set_flags = 1'b0; ex_flags = 2'b00;
    endtask

    logic [7:0] rst_taken;

    initial begin
        stall = 0; flush = 0; br_valid = 0; br_cond = 0;
        ex_idle();
        rst = 1'b1;
        #2 rst = 1'b0;
        step();

        // Reset: F = 00 -> AL, NE, GE, GT taken.
        rst_taken = 8'b0101_0101;
        chk("rst_flags_q", flags_q, 2'b00);
        chk("rst_taken_cnt", taken_cnt, 0);
        br_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            br_cond = 3'(c);
            #1 chk($sformatf("rst_cond%0d", c), br_taken, rst_taken[c]);
            step();
        end
        br_valid = 1'b0;
        #1 chk("rst_br_invalid", br_taken, 1'b0);
        rst = 1'b1;
        step();

        // Commit latency: DEPTH+1 edges.
        ex_write(2'b01);
        step();
        ex_idle();
        chk("lat_edge1", flags_q, 2'b00);
        step();
        chk("lat_edge2", flags_q, 2'b00);
        step();
        chk("lat_edge3", flags_q, 2'b01);

        // Forward priority.
        ex_write(2'b10);
        step();
        ex_write(2'b01);
        step();
        ex_write(2'b10);
        br_valid = 1'b1; br_cond = 3'd1;
        #1 chk("fwd_ex_wins", br_taken, 1'b0);
        ex_idle();
        #1 chk("fwd_stage0_wins", br_taken, 1'b1);
        br_valid = 1'b0;
        step(); step(); step();

        // Asynchronous reset mid-run.
        rst = 1'b0;
        #1 chk("midrst_flags_q", flags_q, 2'b00);
        chk("midrst_taken_cnt", taken_cnt, 0);
        step();
        rst = 1'b1;
        step();

        // Stall holds everything, then commit one edge after release.
        ex_write(2'b10);
        step();
        ex_idle();
        step();
        stall = 1'b1; br_valid = 1'b1; br_cond = 3'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_flags_q", flags_q, 2'b00);
            chk("stall_taken_cnt", taken_cnt, 0);
            chk("stall_fwd_lt", br_taken, 1'b1);
        end
        stall = 1'b0; br_valid = 1'b0;
        step();
        chk("stall_release_commit", flags_q, 2'b10);

        // Flush: oldest commits, younger and EX discarded, no count.
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        ex_write(2'b10);
        step();
        ex_write(2'b01);
        step();
        flush = 1'b1; ex_write(2'b01); br_valid = 1'b1; br_cond = 3'd0;
        step();
        flush = 1'b0; ex_idle();
        chk("flush_commit", flags_q, 2'b10);
        br_cond = 3'd1;
        #1 chk("flush_eq_on_flags_q", br_taken, 1'b0);
        chk("flush_no_count", taken_cnt, 0);
        br_valid = 1'b0;
        step();

        // Counter saturation.
        br_valid = 1'b1; br_cond = 3'd0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_15", taken_cnt, 4'd15);
        step();
        chk("sat_hold", taken_cnt, 4'd15);
        br_valid = 1'b0;

        // Mixed traffic checked by the model each cycle.
        for (int i = 0; i < 200; i++) begin
            stall        = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            ex_valid     = $urandom_range(0, 1);
            ex_set_flags = $urandom_range(0, 1);
            ex_flags     = 2'($urandom_range(0, 3));
            br_valid     = $urandom_range(0, 1);
            br_cond      = 3'($urandom_range(0, 7));
            step();
        end

        done = 1'b1;
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
